// File: rtl/rc4_ksa_fsm_if.sv
// Handshake and shared S-RAM bus between the RC4 KSA controller and its environment.
// The controller takes the master modport; the RAM and neighbouring stages take slave.
interface rc4_ksa_fsm_if;
  logic       start;
  logic       finish_ack;
  logic       done;
  logic [7:0] s_addr;
  logic [7:0] s_data;
  logic       s_wren;
  logic [7:0] s_q;

  modport master (
    input  start, finish_ack, s_q,
    output s_addr, s_data, s_wren, done
  );

  modport slave (
    output start, finish_ack, s_q,
    input  s_addr, s_data, s_wren, done
  );
endinterface

// File: rtl/rc4_ksa_fsm.sv
// RC4 key-scheduling controller: permutes a shared 256x8 S RAM in place.
// Each iteration reads S[i], reads S[j], then writes both halves of the swap.
module rc4_ksa_fsm #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   CLOCK_50,
  input  logic                   rst,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  rc4_ksa_fsm_if.master          bus
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] RD_I = 4'd1;
  localparam logic [3:0] WT_I = 4'd2;
  localparam logic [3:0] RD_J = 4'd3;
  localparam logic [3:0] WT_J = 4'd4;
  localparam logic [3:0] WR_I = 4'd5;
  localparam logic [3:0] WR_J = 4'd6;
  localparam logic [3:0] INC  = 4'd7;
  localparam logic [3:0] DONE = 4'd8;

  logic [3:0]    state;
  logic [7:0]    i, j, si, sj;
  logic [KW-1:0] k;
  logic          inc_hold;
  logic          done_r;
  logic [7:0]    key_byte;

  // Byte 0 of the key sits in the most significant position.
  always_comb begin
    key_byte = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k == KW'(b)) key_byte = secret_key[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  // INC spends two cycles so every iteration is a fixed 8 cycles; done is
  // registered one edge after DONE is entered, and an acknowledge only counts
  // once done is actually visible to the consumer.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      i        <= 8'h00;
      j        <= 8'h00;
      k        <= '0;
      si       <= 8'h00;
      sj       <= 8'h00;
      inc_hold <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i        <= 8'h00;
          j        <= 8'h00;
          k        <= '0;
          inc_hold <= 1'b0;
          if (bus.start) state <= RD_I;
        end
        RD_I: state <= WT_I;
        WT_I: begin
          si    <= bus.s_q;
          j     <= j + bus.s_q + key_byte;
          state <= RD_J;
        end
        RD_J: state <= WT_J;
        WT_J: begin
          sj    <= bus.s_q;
          state <= WR_I;
        end
        WR_I: state <= WR_J;
        WR_J: state <= INC;
        INC: begin
          if (!inc_hold) begin
            inc_hold <= 1'b1;
          end else begin
            inc_hold <= 1'b0;
            if (i == 8'hFF) begin
              state <= DONE;
            end else begin
              i     <= i + 8'd1;
              k     <= (k == K_LAST) ? '0 : k + 1'b1;
              state <= RD_I;
            end
          end
        end
        DONE: if (done_r && bus.finish_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
      done_r <= (state == DONE) && !(done_r && bus.finish_ack);
    end
  end

  // RAM bus is a pure decode of the registered state and datapath registers.
  always_comb begin
    bus.s_addr = 8'h00;
    bus.s_data = 8'h00;
    bus.s_wren = 1'b0;
    case (state)
      RD_I, WT_I: bus.s_addr = i;
      RD_J, WT_J: bus.s_addr = j;
      WR_I: begin
        bus.s_addr = i;
        bus.s_data = sj;
        bus.s_wren = 1'b1;
      end
      WR_J: begin
        bus.s_addr = j;
        bus.s_data = si;
        bus.s_wren = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.done = done_r;

endmodule

// File: tb/tb_rc4_ksa_fsm.sv
// Scoreboard bench for rc4_ksa_fsm: expected RAM writes are queued per run and
// checked by a monitor; final S contents are compared with a reference KSA.
module tb_rc4_ksa_fsm;
  logic        CLOCK_50 = 1'b0;
  logic        rst;
  logic [23:0] key3;
  logic [39:0] key5;
  logic        ram_init3 = 1'b0;
  logic        ram_init5 = 1'b0;
  logic [7:0]  mem3 [256];
  logic [7:0]  mem5 [256];
  logic [7:0]  exp_s [256];
  int          wr_count3 = 0;
  int          pass_count = 0;
  int          total_count = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp3[$];
  wr_t exp5[$];

  rc4_ksa_fsm_if bus3();
  rc4_ksa_fsm_if bus5();

  rc4_ksa_fsm #(.KEY_BYTES(3)) dut3 (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .secret_key(key3),
    .bus       (bus3)
  );

  rc4_ksa_fsm #(.KEY_BYTES(5)) dut5 (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .secret_key(key5),
    .bus       (bus5)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // S RAM models: registered address, one-cycle read latency.
  always @(posedge CLOCK_50) begin
    if (ram_init3) begin
      for (int a = 0; a < 256; a++) mem3[a] <= 8'(a);
    end else if (bus3.s_wren) begin
      mem3[bus3.s_addr] <= bus3.s_data;
      wr_count3 <= wr_count3 + 1;
    end
    bus3.s_q <= mem3[bus3.s_addr];
  end

  always @(posedge CLOCK_50) begin
    if (ram_init5) begin
      for (int a = 0; a < 256; a++) mem5[a] <= 8'(a);
    end else if (bus5.s_wren) begin
      mem5[bus5.s_addr] <= bus5.s_data;
    end
    bus5.s_q <= mem5[bus5.s_addr];
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Monitors: every write pops one queued expectation while any are pending.
  always @(negedge CLOCK_50) begin
    wr_t e;
    if (bus3.s_wren && exp3.size() > 0) begin
      e = exp3.pop_front();
      checkOutput("wr3_addr", int'(bus3.s_addr), int'(e.addr));
      checkOutput("wr3_data", int'(bus3.s_data), int'(e.data));
    end
  end

  always @(negedge CLOCK_50) begin
    wr_t e;
    if (bus5.s_wren && exp5.size() > 0) begin
      e = exp5.pop_front();
      checkOutput("wr5_addr", int'(bus5.s_addr), int'(e.addr));
      checkOutput("wr5_data", int'(bus5.s_data), int'(e.data));
    end
  end

  function automatic void computeModel(input logic [255:0] key, input int n);
    logic [7:0] jj, t, kb;
    for (int a = 0; a < 256; a++) exp_s[a] = 8'(a);
    jj = 8'h00;
    for (int a = 0; a < 256; a++) begin
      kb = key[8*(n-1-(a % n)) +: 8];
      jj = jj + exp_s[a] + kb;
      t = exp_s[a];
      exp_s[a] = exp_s[jj];
      exp_s[jj] = t;
    end
  endfunction

  task automatic compareRam(input int which, input string name);
    int diffs = 0;
    for (int a = 0; a < 256; a++) begin
      if (which == 3 && mem3[a] !== exp_s[a]) diffs++;
      if (which == 5 && mem5[a] !== exp_s[a]) diffs++;
    end
    checkOutput(name, diffs, 0);
  endtask

  task automatic pushWrite(input int which, input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    if (which == 3) exp3.push_back(e);
    else exp5.push_back(e);
  endtask

  task automatic initRam(input int which);
    @(posedge CLOCK_50); #1;
    if (which == 3) ram_init3 = 1'b1; else ram_init5 = 1'b1;
    @(posedge CLOCK_50); #1;
    ram_init3 = 1'b0;
    ram_init5 = 1'b0;
  endtask

  // Returns #1 after the edge that samples start.
  task automatic applyStimulus(input int which, input bit hold);
    @(posedge CLOCK_50); #1;
    if (which == 3) bus3.start = 1'b1; else bus5.start = 1'b1;
    @(posedge CLOCK_50); #1;
    if (!hold) begin
      bus3.start = 1'b0;
      bus5.start = 1'b0;
    end
  endtask

  task automatic waitDone(input int which, input int expect_edges, input string name);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 3000) begin
      @(posedge CLOCK_50); #1;
      n++;
      if ((which == 3) ? bus3.done : bus5.done) seen = 1'b1;
    end
    checkOutput(name, seen ? n : -1, expect_edges);
  endtask

  task automatic ackDone(input int which, input string name);
    if (which == 3) bus3.finish_ack = 1'b1; else bus5.finish_ack = 1'b1;
    @(posedge CLOCK_50); #1;
    bus3.finish_ack = 1'b0;
    bus5.finish_ack = 1'b0;
    checkOutput(name, (which == 3) ? int'(bus3.done) : int'(bus5.done), 0);
  endtask

  initial begin
    int wsnap;
    rst = 1'b1;
    key3 = 24'h000000;
    key5 = 40'h3A7F19C2E5;
    bus3.start = 1'b0;
    bus3.finish_ack = 1'b0;
    bus5.start = 1'b0;
    bus5.finish_ack = 1'b0;
    #5;
    checkOutput("rst_done",  int'(bus3.done),   0);
    checkOutput("rst_wren",  int'(bus3.s_wren), 0);
    checkOutput("rst_addr",  int'(bus3.s_addr), 0);
    checkOutput("rst_data",  int'(bus3.s_data), 0);
    checkOutput("rst_done5", int'(bus5.done),   0);
    repeat (2) @(posedge CLOCK_50);
    #1 rst = 1'b0;

    $display("[TB] run 1: identity S, key 000000");
    initRam(3);
    pushWrite(3, 8'h00, 8'h00); pushWrite(3, 8'h00, 8'h00);
    pushWrite(3, 8'h01, 8'h01); pushWrite(3, 8'h01, 8'h01);
    pushWrite(3, 8'h02, 8'h03); pushWrite(3, 8'h03, 8'h02);
    pushWrite(3, 8'h03, 8'h05); pushWrite(3, 8'h05, 8'h02);
    applyStimulus(3, 1'b0);
    waitDone(3, 2049, "done_latency_key0");
    computeModel(256'h0, 3);
    compareRam(3, "final_S_key0");
    ackDone(3, "ack_key0");

    $display("[TB] run 2: identity S, key 010203");
    key3 = 24'h010203;
    initRam(3);
    pushWrite(3, 8'h00, 8'h01); pushWrite(3, 8'h01, 8'h00);
    pushWrite(3, 8'h01, 8'h03); pushWrite(3, 8'h03, 8'h00);
    applyStimulus(3, 1'b0);
    waitDone(3, 2049, "done_latency_key010203");
    computeModel(256'h010203, 3);
    compareRam(3, "final_S_key010203");
    ackDone(3, "ack_key010203");

    $display("[TB] run 3: start held, done held until acknowledged");
    applyStimulus(3, 1'b1);
    waitDone(3, 2049, "done_latency_held");
    repeat (5) @(posedge CLOCK_50);
    #1 checkOutput("done_held", int'(bus3.done), 1);
    bus3.finish_ack = 1'b1;
    @(posedge CLOCK_50); #1;
    bus3.finish_ack = 1'b0;
    checkOutput("done_after_ack", int'(bus3.done), 0);
    checkOutput("idle_addr", int'(bus3.s_addr), 0);
    waitDone(3, 2050, "restart_latency_held");
    bus3.start = 1'b0;
    ackDone(3, "ack_held");

    $display("[TB] run 4: reset during WR_I of iteration 100");
    key3 = 24'h000000;
    initRam(3);
    applyStimulus(3, 1'b0);
    repeat (804) @(posedge CLOCK_50);
    #1;
    checkOutput("wr_i_iter100_wren", int'(bus3.s_wren), 1);
    checkOutput("wr_i_iter100_addr", int'(bus3.s_addr), 100);
    wsnap = wr_count3;
    #3 rst = 1'b1;
    #1;
    checkOutput("abort_wren", int'(bus3.s_wren), 0);
    checkOutput("abort_done", int'(bus3.done),   0);
    checkOutput("abort_addr", int'(bus3.s_addr), 0);
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkOutput("no_write_in_reset", wr_count3 - wsnap, 0);
    rst = 1'b0;
    initRam(3);
    pushWrite(3, 8'h00, 8'h00); pushWrite(3, 8'h00, 8'h00);
    applyStimulus(3, 1'b0);
    waitDone(3, 2049, "done_latency_after_reset");
    computeModel(256'h0, 3);
    compareRam(3, "final_S_after_reset");
    ackDone(3, "ack_after_reset");

    $display("[TB] run 5: KEY_BYTES=5, key 3A7F19C2E5");
    initRam(5);
    pushWrite(5, 8'h00, 8'h3A); pushWrite(5, 8'h3A, 8'h00);
    pushWrite(5, 8'h01, 8'hBA); pushWrite(5, 8'hBA, 8'h01);
    pushWrite(5, 8'h02, 8'hD5); pushWrite(5, 8'hD5, 8'h02);
    pushWrite(5, 8'h03, 8'h9A); pushWrite(5, 8'h9A, 8'h03);
    pushWrite(5, 8'h04, 8'h83); pushWrite(5, 8'h83, 8'h04);
    pushWrite(5, 8'h05, 8'hC2); pushWrite(5, 8'hC2, 8'h05);
    applyStimulus(5, 1'b0);
    waitDone(5, 2049, "done_latency_k5");
    computeModel(256'h3A7F19C2E5, 5);
    compareRam(5, "final_S_k5");
    ackDone(5, "ack_k5");

    checkOutput("exp3_drained", exp3.size(), 0);
    checkOutput("exp5_drained", exp5.size(), 0);
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end
endmodule
